tlc_safety_monitor: RTL and testbench

- Conflict monitor at the receiving end of the traffic light controller's four light buses (M1, M2, MT, S).
- Samples the lights every clock and checks encoding legality, conflicting permissive aspects, minimum yellow dwell, maximum green dwell and phase stall.
- On any violation it latches a sticky fault and asserts force_flash, which the signal-head driver uses to override the controller. Faults clear only on an explicit clear.

---
 rtl/tlc_pkg.sv | 37 +++
 rtl/tlc_head_dwell.sv | 73 +++++++
 rtl/tlc_safety_monitor.sv | 179 +++++++++++++++++
 tb/tb_tlc_safety_monitor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light conflict monitor.
// Holds aspect encodings, head and fault-cause bit indices, the monitor
// state enum and small aspect classification helpers.
package tlc_pkg;

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    localparam int NUM_HEADS = 4;
    localparam int HEAD_M1   = 0;
    localparam int HEAD_M2   = 1;
    localparam int HEAD_MT   = 2;
    localparam int HEAD_S    = 3;

    localparam int NUM_CAUSES      = 5;
    localparam int CAUSE_ILLEGAL   = 0;
    localparam int CAUSE_CONFLICT  = 1;
    localparam int CAUSE_SHORT_YEL = 2;
    localparam int CAUSE_GREEN_TO  = 3;
    localparam int CAUSE_STALL     = 4;

    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } mon_state_e;

    function automatic logic is_legal(input logic [2:0] a);
        return (a == GREEN) || (a == YELLOW) || (a == RED);
    endfunction

    function automatic logic is_permissive(input logic [2:0] a);
        return (a == GREEN) || (a == YELLOW);
    endfunction

endpackage

// File: rtl/tlc_head_dwell.sv
// Per-head dwell tracker.
// Keeps the previously sampled aspect and a saturating count of consecutive
// samples it has been held, and flags the per-head timing/encoding checks
// against the current sample.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   arm_i             capture current aspect, dwell := 1
//   update_i          normal monitoring update
//   aspect_i          current aspect of this head
//   changed_o         current aspect differs from previous
//   illegal_o         current aspect is not one-hot
//   short_yellow_o    yellow left before MIN_YELLOW samples
//   green_timeout_o   green held longer than MAX_GREEN samples
module tlc_head_dwell
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_GREEN  = 32,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm_i,
    input  logic       update_i,
    input  logic [2:0] aspect_i,
    output logic       changed_o,
    output logic       illegal_o,
    output logic       short_yellow_o,
    output logic       green_timeout_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] dwell_inc, dwell_next;

    assign changed_o  = (aspect_i != prev_q);
    assign illegal_o  = !is_legal(aspect_i);
    assign dwell_inc  = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_ONE;
    assign dwell_next = changed_o ? CNT_ONE : dwell_inc;

    // Short yellow judges the dwell of the aspect being left; green timeout
    // judges the dwell the current sample would produce.
    assign short_yellow_o  = (prev_q == YELLOW) && changed_o &&
                             (dwell_q < CNT_W'(MIN_YELLOW));
    assign green_timeout_o = (aspect_i == GREEN) &&
                             (dwell_next > CNT_W'(MAX_GREEN));

    always_comb begin
        prev_d  = prev_q;
        dwell_d = dwell_q;
        if (arm_i) begin
            prev_d  = aspect_i;
            dwell_d = CNT_ONE;
        end else if (update_i) begin
            prev_d  = aspect_i;
            dwell_d = dwell_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= RED;
            dwell_q <= '0;
        end else begin
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/tlc_safety_monitor.sv
// Conflict monitor on the four traffic light heads (M1, M2, MT, S).
// Checks encoding, conflicting permissive aspects, minimum yellow, maximum
// green and phase stall every sample; any violation latches a sticky fault
// that drives force_flash until an explicit clear.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   light_M1/M2/MT/S    head aspects (one-hot: 001 G, 010 Y, 100 R)
//   clear               fault acknowledge, honoured only in FAULT
//   fault, force_flash  sticky fault (force_flash is a registered copy)
//   fault_cause         [0] illegal [1] conflict [2] short yellow
//                       [3] green timeout [4] stall
//   fault_head          offending heads [0] M1 [1] M2 [2] MT [3] S
//   monitoring          high while checks are active
//
// state   | meaning
// ARMING  | one sample: capture aspects, dwell := 1, stall := 0, no checks
// MONITOR | all checks evaluated every sample
// FAULT   | flags held, counters frozen, wait for clear
module tlc_safety_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_YELLOW  = 3,
    parameter int MAX_GREEN   = 32,
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       clear,
    output logic       fault,
    output logic       force_flash,
    output logic [4:0] fault_cause,
    output logic [3:0] fault_head,
    output logic       monitoring
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mon_state_e state_q, state_d;
    logic                  fault_q, fault_d;
    logic                  force_flash_q;
    logic [NUM_CAUSES-1:0] cause_q, cause_d;
    logic [NUM_HEADS-1:0]  head_q, head_d;
    logic [CNT_W-1:0]      stall_q, stall_d;

    logic [2:0]           aspect [NUM_HEADS];
    logic [NUM_HEADS-1:0] changed, illegal, short_yel, green_to;
    logic [NUM_HEADS-1:0] perm, grn, conflict_head;
    logic                 arm, update, any_changed, stall_fault;
    logic [CNT_W-1:0]     stall_inc;
    logic [NUM_CAUSES-1:0] cause_now;
    logic [NUM_HEADS-1:0]  head_now;

    assign aspect[HEAD_M1] = light_M1;
    assign aspect[HEAD_M2] = light_M2;
    assign aspect[HEAD_MT] = light_MT;
    assign aspect[HEAD_S]  = light_S;

    assign arm    = (state_q == ARMING);
    assign update = (state_q == MONITOR);

    for (genvar g = 0; g < NUM_HEADS; g++) begin : g_head
        tlc_head_dwell #(
            .MIN_YELLOW (MIN_YELLOW),
            .MAX_GREEN  (MAX_GREEN),
            .CNT_W      (CNT_W)
        ) u_dwell (
            .clk             (clk),
            .rst             (rst),
            .arm_i           (arm),
            .update_i        (update),
            .aspect_i        (aspect[g]),
            .changed_o       (changed[g]),
            .illegal_o       (illegal[g]),
            .short_yellow_o  (short_yel[g]),
            .green_timeout_o (green_to[g])
        );
        // Illegal heads are excluded from the conflict matrix.
        assign perm[g] = !illegal[g] && is_permissive(aspect[g]);
        assign grn[g]  = !illegal[g] && (aspect[g] == GREEN);
    end

    // MT yellow against S green is the protected-turn clearance and is legal.
    always_comb begin
        conflict_head = '0;
        if (perm[HEAD_S] && perm[HEAD_M1]) begin
            conflict_head[HEAD_S]  = 1'b1;
            conflict_head[HEAD_M1] = 1'b1;
        end
        if (perm[HEAD_S] && perm[HEAD_M2]) begin
            conflict_head[HEAD_S]  = 1'b1;
            conflict_head[HEAD_M2] = 1'b1;
        end
        if (grn[HEAD_MT] && perm[HEAD_M2]) begin
            conflict_head[HEAD_MT] = 1'b1;
            conflict_head[HEAD_M2] = 1'b1;
        end
        if (grn[HEAD_MT] && grn[HEAD_S]) begin
            conflict_head[HEAD_MT] = 1'b1;
            conflict_head[HEAD_S]  = 1'b1;
        end
    end

    assign any_changed = |changed;
    assign stall_inc   = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_ONE;
    assign stall_fault = !any_changed && (stall_inc > CNT_W'(STALL_LIMIT));

    always_comb begin
        cause_now                  = '0;
        cause_now[CAUSE_ILLEGAL]   = |illegal;
        cause_now[CAUSE_CONFLICT]  = |conflict_head;
        cause_now[CAUSE_SHORT_YEL] = |short_yel;
        cause_now[CAUSE_GREEN_TO]  = |green_to;
        cause_now[CAUSE_STALL]     = stall_fault;
        head_now = illegal | conflict_head | short_yel | green_to;
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        cause_d = cause_q;
        head_d  = head_q;
        stall_d = stall_q;
        case (state_q)
            ARMING: begin
                state_d = MONITOR;
                stall_d = '0;
            end
            MONITOR: begin
                stall_d = any_changed ? '0 : stall_inc;
                if (|cause_now) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    cause_d = cause_q | cause_now;
                    head_d  = head_q | head_now;
                end
            end
            FAULT: begin
                if (clear) begin
                    state_d = ARMING;
                    fault_d = 1'b0;
                    cause_d = '0;
                    head_d  = '0;
                end
            end
            default: state_d = ARMING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARMING;
            fault_q       <= 1'b0;
            force_flash_q <= 1'b0;
            cause_q       <= '0;
            head_q        <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            fault_q       <= fault_d;
            force_flash_q <= fault_d;
            cause_q       <= cause_d;
            head_q        <= head_d;
            stall_q       <= stall_d;
        end
    end

    assign fault       = fault_q;
    assign force_flash = force_flash_q;
    assign fault_cause = cause_q;
    assign fault_head  = head_q;
    assign monitoring  = (state_q == MONITOR);

endmodule

// File: tb/tb_tlc_safety_monitor.sv
// Scoreboard bench for tlc_safety_monitor. The reference model keeps the
// sample history since arming and derives dwell/stall as run lengths.
module tb_tlc_safety_monitor;

    localparam int MIN_YELLOW  = 3;
    localparam int MAX_GREEN   = 32;
    localparam int STALL_LIMIT = 64;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst, clear;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       fault, force_flash, monitoring;
    logic [4:0] fault_cause;
    logic [3:0] fault_head;
    logic [11:0] outs;

    always #5 clk = ~clk;

    tlc_safety_monitor #(
        .MIN_YELLOW  (MIN_YELLOW),
        .MAX_GREEN   (MAX_GREEN),
        .STALL_LIMIT (STALL_LIMIT),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .light_M1    (light_M1),
        .light_M2    (light_M2),
        .light_MT    (light_MT),
        .light_S     (light_S),
        .clear       (clear),
        .fault       (fault),
        .force_flash (force_flash),
        .fault_cause (fault_cause),
        .fault_head  (fault_head),
        .monitoring  (monitoring)
    );

    assign outs = {fault, force_flash, fault_cause, fault_head, monitoring};

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // sample vector packing: {S, MT, M2, M1}, head h at bits [3h+2:3h]
    logic [11:0] hist[$];
    logic [11:0] exp_q[$];
    int          m_state = 0;   // 0 arming, 1 monitoring, 2 faulted
    logic        m_fault = 1'b0;
    logic [4:0]  m_cause = '0;
    logic [3:0]  m_head  = '0;

    function automatic logic [2:0] fld(input logic [11:0] v, input int h);
        return v[h*3 +: 3];
    endfunction

    function automatic logic permissive(input logic [2:0] a);
        return (a == G) || (a == Y);
    endfunction

    function automatic int run_len(input int h);
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (fld(hist[i], h) == fld(hist[hist.size()-1], h)) n++;
            else break;
        end
        return n;
    endfunction

    function automatic int stall_len();
        int n = 0;
        for (int i = hist.size() - 1; i >= 1; i--) begin
            if (hist[i] == hist[i-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_eval(input logic [11:0] v, output logic [4:0] cause,
                              output logic [3:0] head);
        logic [11:0] last;
        logic [2:0]  a, p, s, m1, m2, mt;
        int          run, nd;
        cause = '0;
        head  = '0;
        last  = hist[hist.size()-1];
        for (int h = 0; h < 4; h++) begin
            a   = fld(v, h);
            p   = fld(last, h);
            run = run_len(h);
            if (!(a == G || a == Y || a == R)) begin cause[0] = 1; head[h] = 1; end
            if (p == Y && a != p && run < MIN_YELLOW) begin cause[2] = 1; head[h] = 1; end
            nd = (a != p) ? 1 : run + 1;
            if (a == G && nd > MAX_GREEN) begin cause[3] = 1; head[h] = 1; end
        end
        if (v == last && stall_len() + 1 > STALL_LIMIT) cause[4] = 1;
        m1 = fld(v, 0); m2 = fld(v, 1); mt = fld(v, 2); s = fld(v, 3);
        if (permissive(s) && permissive(m1)) begin cause[1] = 1; head[3] = 1; head[0] = 1; end
        if (permissive(s) && permissive(m2)) begin cause[1] = 1; head[3] = 1; head[1] = 1; end
        if (mt == G && permissive(m2))       begin cause[1] = 1; head[2] = 1; head[1] = 1; end
        if (mt == G && s == G)               begin cause[1] = 1; head[2] = 1; head[3] = 1; end
    endtask

    task automatic model_step(input bit r, input bit c, input logic [11:0] v);
        logic [4:0] cause;
        logic [3:0] head;
        if (r) begin
            m_state = 0; m_fault = 0; m_cause = '0; m_head = '0;
            hist.delete();
        end else if (m_state == 0) begin
            hist.delete();
            hist.push_back(v);
            m_state = 1;
        end else if (m_state == 1) begin
            model_eval(v, cause, head);
            if (cause != '0) begin
                m_state = 2;
                m_fault = 1'b1;
                m_cause |= cause;
                m_head  |= head;
            end
            hist.push_back(v);
            if (hist.size() > 200) void'(hist.pop_front());
        end else if (c) begin
            m_state = 0; m_fault = 0; m_cause = '0; m_head = '0;
        end
        exp_q.push_back({m_fault, m_fault, m_cause, m_head, (m_state == 1)});
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [11:0] sb_exp;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            n_checks++;
            if (outs !== sb_exp) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t {fault,ff,cause,head,mon} actual=%b expected=%b",
                         $time, outs, sb_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [11:0] leg_tab [6];
    int          dur_tab [6];
    int          seq_p, seq_n;
    logic [11:0] cur_v;
    bit          rst_r, clr_r;

    function automatic logic [11:0] pack4(input logic [2:0] m1, input logic [2:0] m2,
                                          input logic [2:0] mt, input logic [2:0] s);
        return {s, mt, m2, m1};
    endfunction

    task automatic stepv(input logic [11:0] v);
        rst = rst_r;
        clear = clr_r;
        light_M1 = fld(v, 0);
        light_M2 = fld(v, 1);
        light_MT = fld(v, 2);
        light_S  = fld(v, 3);
        cur_v = v;
        model_step(rst_r, clr_r, v);
        @(posedge clk);
        #1;
    endtask

    task automatic run_phase(input int p, input int n);
        repeat (n) stepv(leg_tab[p]);
    endtask

    task automatic next_legal(output logic [11:0] v);
        v = leg_tab[seq_p];
        seq_n--;
        if (seq_n <= 0) begin
            seq_p = (seq_p + 1) % 6;
            seq_n = dur_tab[seq_p];
        end
    endtask

    task automatic dcheck(input string name, input logic [11:0] exp);
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s {fault,ff,cause,head,mon} actual=%b expected=%b", name, outs, exp);
        end
    endtask

    int          r, h, n;
    logic [11:0] v;

    initial begin
        leg_tab[0] = pack4(G, G, R, R); dur_tab[0] = 8;
        leg_tab[1] = pack4(G, Y, R, R); dur_tab[1] = 3;
        leg_tab[2] = pack4(G, R, R, R); dur_tab[2] = 6;
        leg_tab[3] = pack4(Y, R, Y, R); dur_tab[3] = 6;
        leg_tab[4] = pack4(R, R, Y, G); dur_tab[4] = 4;
        leg_tab[5] = pack4(R, R, Y, R); dur_tab[5] = 3;

        rst_r = 1; clr_r = 0;
        stepv(pack4(R, R, R, R));
        stepv(pack4(R, R, R, R));
        dcheck("reset_state", 12'b0);
        rst_r = 0;

        // legal sequence, five full rotations
        run_phase(0, 1);
        dcheck("arming_one_cycle", {1'b0, 1'b0, 5'b0, 4'b0, 1'b1});
        run_phase(0, 7);
        for (int p = 1; p < 6; p++) run_phase(p, dur_tab[p]);
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 6; p++) run_phase(p, dur_tab[p]);
        dcheck("legal_no_fault", {1'b0, 1'b0, 5'b0, 4'b0, 1'b1});

        // conflict: S green against M1 green
        run_phase(0, 8);
        run_phase(1, 3);
        stepv(pack4(G, R, R, G));
        dcheck("conflict", {1'b1, 1'b1, 5'b00010, 4'b1001, 1'b0});
        stepv(pack4(G, R, R, R));
        dcheck("fault_sticky", {1'b1, 1'b1, 5'b00010, 4'b1001, 1'b0});
        clr_r = 1;
        stepv(leg_tab[0]);
        dcheck("clear_to_arming", 12'b0);
        clr_r = 0;
        stepv(leg_tab[0]);
        dcheck("arming_to_monitor", {1'b0, 1'b0, 5'b0, 4'b0, 1'b1});

        // short yellow on M2
        run_phase(0, 7);
        run_phase(1, 2);
        run_phase(2, 1);
        dcheck("short_yellow", {1'b1, 1'b1, 5'b00100, 4'b0010, 1'b0});

        // green timeout boundary
        clr_r = 1; stepv(leg_tab[0]); clr_r = 0;
        run_phase(0, 32);
        dcheck("green_32_ok", {1'b0, 1'b0, 5'b0, 4'b0, 1'b1});
        run_phase(0, 1);
        dcheck("green_timeout", {1'b1, 1'b1, 5'b01000, 4'b0011, 1'b0});

        // illegal encoding on MT
        clr_r = 1; stepv(leg_tab[0]); clr_r = 0;
        run_phase(0, 3);
        stepv(pack4(G, G, 3'b011, R));
        dcheck("illegal_mt", {1'b1, 1'b1, 5'b00001, 4'b0100, 1'b0});

        // stall boundary
        clr_r = 1; stepv(pack4(R, R, R, R)); clr_r = 0;
        repeat (65) stepv(pack4(R, R, R, R));
        dcheck("stall_64_ok", {1'b0, 1'b0, 5'b0, 4'b0, 1'b1});
        stepv(pack4(R, R, R, R));
        dcheck("stall", {1'b1, 1'b1, 5'b10000, 4'b0000, 1'b0});

        // reset overrides FAULT; clear ignored in MONITOR
        rst_r = 1;
        stepv(leg_tab[0]);
        dcheck("rst_in_fault", 12'b0);
        rst_r = 0;
        stepv(leg_tab[0]);
        dcheck("rst_then_monitor", {1'b0, 1'b0, 5'b0, 4'b0, 1'b1});
        clr_r = 1;
        stepv(leg_tab[0]);
        dcheck("clear_in_monitor", {1'b0, 1'b0, 5'b0, 4'b0, 1'b1});
        clr_r = 0;

        // randomized legal traffic with injected faults
        seq_p = 0; seq_n = dur_tab[0] - 2;
        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 999);
            clr_r = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            rst_r = (r < 4);
            if (r < 4) begin
                v = cur_v;
            end else if (r < 20) begin
                next_legal(v);
                h = $urandom_range(0, 3);
                v[h*3 +: 3] = 3'($urandom_range(0, 7));
            end else if (r < 35) begin
                seq_p = (seq_p + 1) % 6;
                seq_n = dur_tab[seq_p];
                next_legal(v);
            end else if (r < 40) begin
                n = $urandom_range(30, 70);
                repeat (n) stepv(cur_v);
                v = cur_v;
            end else begin
                next_legal(v);
            end
            stepv(v);
            rst_r = 0;
        end
        clr_r = 0;

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
